// File: rtl/pipeline_hazard_unit.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_unit
//
// Hazard and forwarding controller for the in-order RV32 pipeline. It sits
// beside decode and keeps a private scoreboard of the destinations that are
// in flight in the stages downstream of decode (slot0 = EX, slot1 = MEM,
// slot2 = WB, ...). From that scoreboard, the FSM state and the decode fields,
// it produces the front-end stall, the flush/bubble controls and the
// per-operand forwarding selects.
//
// Handshake / control semantics (single description for every control here):
//   stall_o      : PC and fetch/decode register keep their value this cycle.
//   flush_fd_o   : fetch/decode register is cleared at the next edge.
//   bubble_de_o  : decode/execute register loads a bubble at the next edge.
//   ex_hold_o    : EX keeps its current (multi-cycle) instruction.
//   All controls are combinational and apply to the upcoming rising edge.
//
// Ports:
//   clk_i, reset_i          clock, asynchronous active-high reset
//   id_*                    decode-stage instruction fields
//   ex_branch_taken_i       EX redirects the PC this cycle
//   stall_o, flush_fd_o,
//   bubble_de_o, ex_hold_o  pipeline control outputs
//   fwd_rs1_sel_o,
//   fwd_rs2_sel_o           0 = register file, k = result from slot k-1
//   state_o                 FSM state for debug (00 RUN, 01 MUL_WAIT)
// -----------------------------------------------------------------------------
module pipeline_hazard_unit #(
    parameter int NUM_FWD_STAGES = 3,
    parameter int REG_ADDR_W     = 5,
    parameter int MUL_LATENCY    = 3,
    parameter int SEL_W          = 3
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  id_valid_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_reg_write_i,
    input  logic                  id_is_load_i,
    input  logic                  id_is_mul_i,
    input  logic                  ex_branch_taken_i,
    output logic                  stall_o,
    output logic                  flush_fd_o,
    output logic                  bubble_de_o,
    output logic                  ex_hold_o,
    output logic [SEL_W-1:0]      fwd_rs1_sel_o,
    output logic [SEL_W-1:0]      fwd_rs2_sel_o,
    output logic [1:0]            state_o
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MUL_WAIT = 2'b01
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  is_load;
    } sb_entry_t;

    localparam sb_entry_t BUBBLE = sb_entry_t'('0);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    sb_entry_t  sb_q [NUM_FWD_STAGES];
    sb_entry_t  sb_d [NUM_FWD_STAGES];

    logic [SEL_W-1:0] rs1_sel;
    logic [SEL_W-1:0] rs2_sel;
    logic             rs1_from_ex;
    logic             rs2_from_ex;
    logic             load_use;

    // ------------------------------------------------------------------
    // Forwarding match. Scanning from the oldest slot down to slot0 lets
    // the youngest producer overwrite older matches.
    // ------------------------------------------------------------------
    always_comb begin
        rs1_sel = '0;
        rs2_sel = '0;
        for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
            if (sb_q[k].valid && sb_q[k].reg_write && id_rs1_used_i &&
                id_rs1_i != '0 && sb_q[k].rd == id_rs1_i) begin
                rs1_sel = SEL_W'(k + 1);
            end
            if (sb_q[k].valid && sb_q[k].reg_write && id_rs2_used_i &&
                id_rs2_i != '0 && sb_q[k].rd == id_rs2_i) begin
                rs2_sel = SEL_W'(k + 1);
            end
        end
        rs1_from_ex = (rs1_sel == SEL_W'(1));
        rs2_from_ex = (rs2_sel == SEL_W'(1));
        load_use    = id_valid_i && sb_q[0].is_load && (rs1_from_ex || rs2_from_ex);
    end

    // ------------------------------------------------------------------
    // Next state, scoreboard update and control outputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        stall_o       = 1'b0;
        flush_fd_o    = 1'b0;
        bubble_de_o   = 1'b0;
        ex_hold_o     = 1'b0;
        fwd_rs1_sel_o = '0;
        fwd_rs2_sel_o = '0;

        for (int k = 0; k < NUM_FWD_STAGES; k++) begin
            sb_d[k] = sb_q[k];
        end
        // Default shift of the downstream slots; slot0 is decided below.
        for (int k = 1; k < NUM_FWD_STAGES; k++) begin
            sb_d[k] = sb_q[k-1];
        end

        if (id_valid_i) begin
            fwd_rs1_sel_o = rs1_sel;
            fwd_rs2_sel_o = rs2_sel;
        end

        unique case (state_q)
            MUL_WAIT: begin
                stall_o   = 1'b1;
                ex_hold_o = 1'b1;
                // The MUL in EX has no result yet, so slot0 is never a source.
                if (rs1_from_ex) fwd_rs1_sel_o = '0;
                if (rs2_from_ex) fwd_rs2_sel_o = '0;
                // EX keeps the MUL; MEM receives nothing.
                sb_d[0] = sb_q[0];
                sb_d[1] = BUBBLE;
                if (cnt_q <= 4'd1) begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RUN: begin
                if (ex_branch_taken_i) begin
                    // Redirect wins over a load-use stall: the ID instruction is dead.
                    flush_fd_o  = 1'b1;
                    bubble_de_o = 1'b1;
                    sb_d[0]     = BUBBLE;
                end else if (load_use) begin
                    stall_o     = 1'b1;
                    bubble_de_o = 1'b1;
                    sb_d[0]     = BUBBLE;
                end else begin
                    sb_d[0].valid     = id_valid_i;
                    sb_d[0].rd        = id_rd_i;
                    sb_d[0].reg_write = id_reg_write_i;
                    sb_d[0].is_load   = id_is_load_i;
                    if (id_valid_i && id_is_mul_i && MUL_LATENCY > 1) begin
                        state_d = MUL_WAIT;
                        cnt_d   = 4'(MUL_LATENCY - 1);
                    end
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase

        // Reset has top priority on the combinational outputs too.
        if (reset_i) begin
            stall_o       = 1'b0;
            flush_fd_o    = 1'b0;
            bubble_de_o   = 1'b0;
            ex_hold_o     = 1'b0;
            fwd_rs1_sel_o = '0;
            fwd_rs2_sel_o = '0;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            for (int k = 0; k < NUM_FWD_STAGES; k++) begin
                sb_q[k] <= BUBBLE;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            for (int k = 0; k < NUM_FWD_STAGES; k++) begin
                sb_q[k] <= sb_d[k];
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;

    logic       clk;
    logic       reset_i;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_reg_write;
    logic       id_is_load;
    logic       id_is_mul;
    logic       ex_branch_taken;
    logic       stall_o;
    logic       flush_fd_o;
    logic       bubble_de_o;
    logic       ex_hold_o;
    logic [2:0] fwd_rs1_sel_o;
    logic [2:0] fwd_rs2_sel_o;
    logic [1:0] state_o;

    int total = 0;
    int bad   = 0;

    // Packed expectation: {stall, flush, bubble, hold, sel1[2:0], sel2[2:0], state[1:0]}
    logic [11:0] exp_q[$];
    string       tag_q[$];

    pipeline_hazard_unit #(
        .NUM_FWD_STAGES(3),
        .REG_ADDR_W    (5),
        .MUL_LATENCY   (3),
        .SEL_W         (3)
    ) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .id_valid_i       (id_valid),
        .id_rs1_i         (id_rs1),
        .id_rs2_i         (id_rs2),
        .id_rs1_used_i    (id_rs1_used),
        .id_rs2_used_i    (id_rs2_used),
        .id_rd_i          (id_rd),
        .id_reg_write_i   (id_reg_write),
        .id_is_load_i     (id_is_load),
        .id_is_mul_i      (id_is_mul),
        .ex_branch_taken_i(ex_branch_taken),
        .stall_o          (stall_o),
        .flush_fd_o       (flush_fd_o),
        .bubble_de_o      (bubble_de_o),
        .ex_hold_o        (ex_hold_o),
        .fwd_rs1_sel_o    (fwd_rs1_sel_o),
        .fwd_rs2_sel_o    (fwd_rs2_sel_o),
        .state_o          (state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        id_valid        = 1'b0;
        id_rs1          = '0;
        id_rs2          = '0;
        id_rs1_used     = 1'b0;
        id_rs2_used     = 1'b0;
        id_rd           = '0;
        id_reg_write    = 1'b0;
        id_is_load      = 1'b0;
        id_is_mul       = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    // Presents one decode instruction after the falling edge. Loads read rs1 only.
    task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic ld, input logic mul, input logic br);
        @(negedge clk);
        id_valid        = 1'b1;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_rs1_used     = 1'b1;
        id_rs2_used     = !ld;
        id_rd           = rd;
        id_reg_write    = 1'b1;
        id_is_load      = ld;
        id_is_mul       = mul;
        ex_branch_taken = br;
    endtask

    task automatic expect_out(input string tag, input logic stall, input logic flush,
                              input logic bubble, input logic hold, input logic [2:0] s1,
                              input logic [2:0] s2, input logic [1:0] st);
        exp_q.push_back({stall, flush, bubble, hold, s1, s2, st});
        tag_q.push_back(tag);
    endtask

    // ---------------- scoreboard ----------------
    task automatic check_out();
        logic [11:0] exp_v;
        logic [11:0] obs_v;
        string       tag;
        #1;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty observed=none expected=entry");
        end else begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            obs_v = {stall_o, flush_fd_o, bubble_de_o, ex_hold_o,
                     fwd_rs1_sel_o, fwd_rs2_sel_o, state_o};
            assert (obs_v === exp_v) else begin
                bad++;
                $error("FAIL %s observed=%b expected=%b (stall flush bubble hold sel1 sel2 state)",
                       tag, obs_v, exp_v);
            end
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        idle_inputs();
        reset_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        expect_out("reset_state", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();
        reset_i = 1'b0;

        // Forwarding ladder on x5.
        issue(5'd5, 5'd1, 5'd2, 0, 0, 0);      // add x5,x1,x2
        expect_out("ladder_producer", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();
        issue(5'd6, 5'd5, 5'd1, 0, 0, 0);      // sub x6,x5,x1
        expect_out("ladder_sel1", 0, 0, 0, 0, 3'd1, 3'd0, 2'b00);
        check_out();
        issue(5'd7, 5'd5, 5'd1, 0, 0, 0);      // one instruction between
        expect_out("ladder_sel2", 0, 0, 0, 0, 3'd2, 3'd0, 2'b00);
        check_out();
        issue(5'd8, 5'd5, 5'd1, 0, 0, 0);      // two between
        expect_out("ladder_sel3", 0, 0, 0, 0, 3'd3, 3'd0, 2'b00);
        check_out();
        issue(5'd9, 5'd5, 5'd8, 0, 0, 0);      // three between; rs2=x8 is youngest
        expect_out("ladder_sel0_rs2_sel1", 0, 0, 0, 0, 3'd0, 3'd1, 2'b00);
        check_out();

        // Load-use.
        issue(5'd7, 5'd1, 5'd0, 1, 0, 0);      // lw x7,0(x1)
        expect_out("load_issue", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();
        issue(5'd8, 5'd7, 5'd7, 0, 0, 0);      // add x8,x7,x7
        expect_out("load_use_stall", 1, 0, 1, 0, 3'd1, 3'd1, 2'b00);
        check_out();
        issue(5'd8, 5'd7, 5'd7, 0, 0, 0);      // same instruction, load now in MEM
        expect_out("load_use_after", 0, 0, 0, 0, 3'd2, 3'd2, 2'b00);
        check_out();

        // x0 guard with a load producer.
        issue(5'd0, 5'd1, 5'd0, 1, 0, 0);      // lw x0,0(x1)
        expect_out("x0_load", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();
        issue(5'd10, 5'd0, 5'd0, 0, 0, 0);     // add x10,x0,x0
        expect_out("x0_consumer", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();

        // MUL occupancy (latency 3 -> two MUL_WAIT cycles).
        issue(5'd11, 5'd1, 5'd2, 0, 1, 0);     // mul x11,x1,x2
        expect_out("mul_issue", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();
        issue(5'd12, 5'd11, 5'd0, 0, 0, 0);    // add x12,x11,x0 waits in ID
        expect_out("mul_wait_1", 1, 0, 0, 1, 3'd0, 3'd0, 2'b01);
        check_out();
        issue(5'd12, 5'd11, 5'd0, 0, 0, 0);
        expect_out("mul_wait_2", 1, 0, 0, 1, 3'd0, 3'd0, 2'b01);
        check_out();
        issue(5'd12, 5'd11, 5'd0, 0, 0, 0);
        expect_out("mul_done_fwd", 0, 0, 0, 0, 3'd1, 3'd0, 2'b00);
        check_out();

        // Branch in the same cycle as a load-use match.
        issue(5'd13, 5'd1, 5'd0, 1, 0, 0);     // lw x13
        expect_out("br_load_issue", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();
        issue(5'd14, 5'd13, 5'd2, 0, 0, 1);    // add x14,x13,x2 + taken branch
        expect_out("branch_over_load_use", 0, 1, 1, 0, 3'd1, 3'd0, 2'b00);
        check_out();
        issue(5'd15, 5'd13, 5'd12, 0, 0, 0);   // slot0 now a bubble
        expect_out("after_flush_slot0_empty", 0, 0, 0, 0, 3'd2, 3'd3, 2'b00);
        check_out();

        // Branch ignored in MUL_WAIT, then asynchronous reset while counter=2.
        issue(5'd16, 5'd1, 5'd2, 0, 1, 0);     // mul x16
        expect_out("mul2_issue", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();
        issue(5'd17, 5'd16, 5'd15, 0, 0, 1);   // dependent add + branch (ignored)
        expect_out("mul_wait_branch_ignored", 1, 0, 0, 1, 3'd0, 3'd2, 2'b01);
        check_out();
        ex_branch_taken = 1'b0;
        reset_i = 1'b1;                        // mid-cycle, well before the next edge
        expect_out("async_reset_mid_mul", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();
        @(negedge clk);
        reset_i = 1'b0;
        issue(5'd17, 5'd16, 5'd15, 0, 0, 0);
        expect_out("post_reset_consumer", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();

        // id_valid low: fields ignored, bubble enters slot0.
        @(negedge clk);
        idle_inputs();
        id_rs1 = 5'd17;
        id_rs1_used = 1'b1;
        expect_out("invalid_id", 0, 0, 0, 0, 3'd0, 3'd0, 2'b00);
        check_out();
        issue(5'd18, 5'd17, 5'd1, 0, 0, 0);    // x17 producer now in slot1
        expect_out("valid_after_bubble", 0, 0, 0, 0, 3'd2, 3'd0, 2'b00);
        check_out();

        @(negedge clk);
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
